pairing_cmd_ctrl: RTL and testbench

- Command front-end that sits directly upstream of the microcode sequencer.
- Accepts function commands (pairing / Miller loop / final exponentiation) from the host over a valid/ready interface and buffers them in a small FIFO.
- Launches the sequencer with a one-cycle run pulse plus a held function number, then tracks the sequencer's busy flag to completion.
- Returns a tagged response carrying the elapsed cycle count and an error flag.

---
 rtl/pairing_cmd_ctrl.sv | 117 +++++++++++
 tb/tb_pairing_cmd_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pairing_cmd_ctrl.sv
// pairing_cmd_ctrl: buffers host function commands, launches the microcode sequencer
// one at a time, and returns a tagged response with the elapsed cycle count.
module pairing_cmd_ctrl #(
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 32,
  parameter int START_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_func,
  input  logic [3:0]       cmd_tag,
  input  logic             seq_busy,
  output logic             seq_run,
  output logic [3:0]       seq_n_func,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_tag,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             rsp_err,
  output logic             idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_RESP} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_count;
  logic             w_full, w_empty, w_push, w_pop, w_hbad, w_tmo_hit, w_launch;
  logic [3:0]       w_hfunc, w_htag;
  logic [CNT_W-1:0] r_cyc, w_cyc_inc;
  logic [TW-1:0]    r_tmo;
  logic             r_seq_run, r_rsp_err;
  logic [3:0]       r_seq_n_func, r_rsp_tag;
  logic [CNT_W-1:0] r_rsp_cycles;
  assign w_full     = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_empty    = r_count == '0;
  assign w_push     = cmd_valid && !w_full;
  assign {w_hfunc, w_htag} = r_mem[r_rp];
  assign w_hbad     = w_hfunc > 4'd2;
  assign w_pop      = (r_state == S_IDLE && !w_empty && w_hbad) || r_state == S_LAUNCH;
  assign w_launch   = r_state == S_IDLE && w_next == S_LAUNCH;
  assign w_cyc_inc  = &r_cyc ? r_cyc : r_cyc + 1'b1;
  assign w_tmo_hit  = r_tmo == TW'(START_TIMEOUT - 1);
  assign cmd_ready  = !w_full;
  assign seq_run    = r_seq_run;
  assign seq_n_func = r_seq_n_func;
  assign rsp_valid  = r_state == S_RESP;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_cycles = r_rsp_cycles;
  assign rsp_err    = r_rsp_err;
  assign idle       = w_empty && r_state == S_IDLE;
  always_ff @(posedge clk)
    r_state <= !rstn ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = w_empty ? S_IDLE : w_hbad ? S_RESP : seq_busy ? S_IDLE : S_LAUNCH;
      S_LAUNCH:    w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: w_next = seq_busy ? S_RUN : w_tmo_hit ? S_RESP : S_WAIT_BUSY;
      S_RUN:       w_next = seq_busy ? S_RUN : S_RESP;
      S_RESP:      w_next = rsp_ready ? S_IDLE : S_RESP;
      default:     w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= {cmd_func, cmd_tag};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // Response fields only load outside RESP, so they stay stable while the host stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_seq_run    <= 1'b0;
      r_seq_n_func <= '0;
      r_rsp_tag    <= '0;
      r_rsp_cycles <= '0;
      r_rsp_err    <= 1'b0;
      r_cyc        <= '0;
      r_tmo        <= '0;
    end else begin
      r_seq_run <= w_launch;
      if (w_launch) r_seq_n_func <= w_hfunc;
      if (r_state == S_IDLE && !w_empty && w_hbad) begin
        r_rsp_tag    <= w_htag;
        r_rsp_err    <= 1'b1;
        r_rsp_cycles <= '0;
      end
      if (r_state == S_LAUNCH) begin
        r_rsp_tag <= w_htag;
        r_cyc     <= '0;
        r_tmo     <= '0;
      end
      if (r_state == S_WAIT_BUSY || r_state == S_RUN) r_cyc <= w_cyc_inc;
      if (r_state == S_WAIT_BUSY) r_tmo <= r_tmo + 1'b1;
      if (r_state == S_WAIT_BUSY && !seq_busy && w_tmo_hit) begin
        r_rsp_err    <= 1'b1;
        r_rsp_cycles <= w_cyc_inc;
      end
      if (r_state == S_RUN && !seq_busy) begin
        r_rsp_err    <= 1'b0;
        r_rsp_cycles <= w_cyc_inc;
      end
    end
  end
endmodule

// File: tb/tb_pairing_cmd_ctrl.sv
// tb_pairing_cmd_ctrl: scoreboard bench with a behavioural sequencer and response model;
// a 4-bit counter makes saturation reachable with short busy periods.
module tb_pairing_cmd_ctrl;
  localparam int CW  = 4;
  localparam int TMO = 8;
  localparam int SAT = (1 << CW) - 1;
  logic          clk = 1'b0, rstn = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic [3:0]    cmd_func = '0, cmd_tag = '0;
  logic          cmd_ready, seq_busy, seq_run, rsp_valid, rsp_err, idle;
  logic [3:0]    seq_n_func, rsp_tag;
  logic [CW-1:0] rsp_cycles;
  typedef struct {logic [3:0] tag; int cyc; int err;} rsp_t;
  typedef struct {logic [3:0] func; int dur;} lch_t;
  rsp_t exp_q[$];
  lch_t lch_q[$];
  int   dur_q[$];
  int   checks = 0, errors = 0, cyc = 0, bcnt = 0, rdy_mode = 2;
  pairing_cmd_ctrl #(.FIFO_DEPTH(4), .CNT_W(CW), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_tag(cmd_tag), .seq_busy(seq_busy), .seq_run(seq_run),
    .seq_n_func(seq_n_func), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_cycles(rsp_cycles), .rsp_err(rsp_err), .idle(idle)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Sequencer: busy rises the cycle after run and stays up for the command's duration;
  // a duration of 0 means busy never rises.
  always @(posedge clk) begin
    if (!rstn) bcnt <= 0;
    else if (seq_run) begin
      if (dur_q.size() > 0) bcnt <= dur_q.pop_front();
    end else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign seq_busy = bcnt != 0;
  function automatic void chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endfunction
  initial forever begin
    @(posedge clk);
    #1;
    rsp_ready = rdy_mode == 2 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
  end
  // Monitor: response scoreboard, hold stability, launch function and spacing.
  initial begin
    logic       pv, prun;
    logic [3:0] ptag;
    int         pcyc, perr, last_run, last_dur;
    rsp_t       e;
    lch_t       l;
    pv = 0; prun = 0; last_run = -1; last_dur = 0; ptag = '0; pcyc = 0; perr = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pv = 0; prun = 0; last_run = -1;
      end else begin
        if (pv) begin
          chk("hold_valid", rsp_valid, 1);
          chk("hold_tag", rsp_tag, ptag);
          chk("hold_cycles", rsp_cycles, pcyc);
          chk("hold_err", rsp_err, perr);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual tag=%0d required none", rsp_tag);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_tag", rsp_tag, e.tag);
            chk("rsp_cycles", rsp_cycles, e.cyc);
            chk("rsp_err", rsp_err, e.err);
          end
        end
        pv = rsp_valid && !rsp_ready; ptag = rsp_tag; pcyc = rsp_cycles; perr = rsp_err;
        if (seq_run) begin
          chk("run_single_cycle", prun, 0);
          if (lch_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_run actual func=%0d required no launch", seq_n_func);
          end else begin
            l = lch_q.pop_front();
            chk("seq_n_func", seq_n_func, l.func);
            if (last_run >= 0) begin
              checks++;
              if (cyc - last_run < (last_dur == 0 ? TMO + 3 : last_dur + 4)) begin
                errors++;
                $display("FAIL run_gap actual=%0d required>=%0d", cyc - last_run,
                         last_dur == 0 ? TMO + 3 : last_dur + 4);
              end
            end
            last_run = cyc; last_dur = l.dur;
          end
        end
        prun = seq_run;
      end
    end
  end
  task automatic send(input logic [3:0] f, input logic [3:0] t, input int d);
    int n = 0;
    cmd_valid = 1'b1; cmd_func = f; cmd_tag = t;
    while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout actual cmd_ready=0 required 1 tag=%0d", t);
    end else begin
      rsp_t e;
      e.tag = t;
      e.err = (f > 2 || d == 0) ? 1 : 0;
      e.cyc = f > 2 ? 0 : d == 0 ? TMO : (d + 1 > SAT ? SAT : d + 1);
      exp_q.push_back(e);
      if (f <= 2) begin lch_q.push_back('{f, d}); dur_q.push_back(d); end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 5000) begin @(negedge clk); n++; end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_idle", idle, 1);
  endtask
  task automatic chk_reset_outs(string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_seq_run"}, seq_run, 0);
    chk({tag, "_seq_n_func"}, seq_n_func, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_tag"}, rsp_tag, 0);
    chk({tag, "_rsp_cycles"}, rsp_cycles, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_rst");
    send(4'd1, 4'd5, 10);
    drain();
    @(negedge clk);
    send(4'd7, 4'd3, 5);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 2);
    chk("invalid_latency", rsp_valid, 1);
    drain();
    rdy_mode = 0;
    @(negedge clk);
    send(4'd0, 4'd1, 20);
    send(4'd1, 4'd2, 20);
    send(4'd2, 4'd4, 20);
    send(4'd0, 4'd6, 20);
    send(4'd1, 4'd8, 20);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_idle", idle, 0);
    repeat (10) @(negedge clk);
    rdy_mode = 1;
    drain();
    rdy_mode = 2;
    @(negedge clk);
    send(4'd2, 4'd9, 0);
    send(4'd0, 4'd10, 4);
    drain();
    rdy_mode = 0;
    @(negedge clk);
    send(4'd0, 4'd12, 30);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("sat_rsp_valid", rsp_valid, 1);
    repeat (6) @(negedge clk);
    rdy_mode = 2;
    drain();
    @(negedge clk);
    send(4'd1, 4'd11, 20);
    send(4'd2, 4'd13, 20);
    n = 0;
    while (!seq_run && n < 50) begin @(negedge clk); n++; end
    chk("mid_run_launched", seq_run, 1);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    exp_q.delete(); lch_q.delete(); dur_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    chk_reset_outs("mid_rst");
    repeat (10) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_valid, 0);
    chk("mid_rst_still_idle", idle, 1);
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] f;
      int         d;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      f = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, 2));
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30);
      send(f, 4'($urandom_range(0, 15)), d);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
